// File: rtl/modfa_arb.sv
// -----------------------------------------------------------------------------
// modfa_arb
// Round-robin arbiter and sequencer that shares one fixed-latency modular adder
// (op1 + op2 + cin mod mod, en/vld handshake) among NREQ requesters.
// The winner's operands are captured into the adder input registers. The adder
// gets a one-cycle enable, and the arbiter then waits for its valid. The sum is
// then returned to the owning requester. A watchdog bounds the wait to TMO
// cycles, so a requester is always answered.
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]        request per requester, held until gnt seen
//   op1_in   in   [NREQ*WIDTH]  operand 1, slice i belongs to requester i
//   op2_in   in   [NREQ*WIDTH]  operand 2, slice i belongs to requester i
//   cin_in   in   [NREQ]        carry-in per requester
//   mod_in   in   [WIDTH]       shared modulus, sampled at grant
//   gnt      out  [NREQ]        one-hot pulse: operands captured
//   fa_op1   out  [WIDTH]       adder operand 1 (held until next grant)
//   fa_op2   out  [WIDTH]       adder operand 2 (held until next grant)
//   fa_mod   out  [WIDTH]       adder modulus (held until next grant)
//   fa_cin   out  1             adder carry-in (held until next grant)
//   fa_en    out  1             adder enable pulse
//   fa_sum   in   [WIDTH]       adder sum
//   fa_vld   in   1             adder valid
//   res      out  [WIDTH]       result to owner (0 on timeout)
//   res_vld  out  [NREQ]        one-hot pulse to owner
//   tmo_err  out  1             pulse alongside res_vld on timeout
//   busy     out  1             operation in flight
// -----------------------------------------------------------------------------
module modfa_arb #(
    parameter int WIDTH = 256,
    parameter int NREQ  = 4,
    parameter int TMO   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op1_in,
    input  logic [NREQ*WIDTH-1:0]   op2_in,
    input  logic [NREQ-1:0]         cin_in,
    input  logic [WIDTH-1:0]        mod_in,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        fa_op1,
    output logic [WIDTH-1:0]        fa_op2,
    output logic [WIDTH-1:0]        fa_mod,
    output logic                    fa_cin,
    output logic                    fa_en,
    input  logic [WIDTH-1:0]        fa_sum,
    input  logic                    fa_vld,
    output logic [WIDTH-1:0]        res,
    output logic [NREQ-1:0]         res_vld,
    output logic                    tmo_err,
    output logic                    busy
);

    localparam int CW = $clog2(TMO + 1);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [CW-1:0]    r_cnt;
    logic [NREQ-1:0]  r_gnt;
    logic [WIDTH-1:0] r_fa_op1;
    logic [WIDTH-1:0] r_fa_op2;
    logic [WIDTH-1:0] r_fa_mod;
    logic             r_fa_cin;
    logic             r_fa_en;
    logic [WIDTH-1:0] r_res;
    logic [NREQ-1:0]  r_res_vld;
    logic             r_tmo_err;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_ptr_nxt;
    logic [NREQ-1:0]  w_owner_oh;
    logic [WIDTH-1:0] w_op1 [NREQ];
    logic [WIDTH-1:0] w_op2 [NREQ];

    // Unpack the flat operand buses into per-requester slices
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign w_op1[g] = op1_in[g*WIDTH +: WIDTH];
        assign w_op2[g] = op2_in[g*WIDTH +: WIDTH];
    end

    // Round-robin pick: first request found scanning ptr, ptr+1, ... modulo NREQ
    always_comb begin
        w_found = 1'b0;
        w_win   = {PW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req[PW'(idx)]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end else begin
                w_found = w_found;
            end
        end
    end

    // Priority pointer moves just past the winner, wrapping at NREQ
    always_comb begin
        w_ptr_nxt = {PW{1'b0}};
        if (w_win == PW'(NREQ - 1)) begin
            w_ptr_nxt = {PW{1'b0}};
        end else begin
            w_ptr_nxt = w_win + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;

    // Arbiter/sequencer state machine with registered pulses and adder inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= {PW{1'b0}};
            r_owner   <= {PW{1'b0}};
            r_cnt     <= {CW{1'b0}};
            r_gnt     <= {NREQ{1'b0}};
            r_fa_op1  <= {WIDTH{1'b0}};
            r_fa_op2  <= {WIDTH{1'b0}};
            r_fa_mod  <= {WIDTH{1'b0}};
            r_fa_cin  <= 1'b0;
            r_fa_en   <= 1'b0;
            r_res     <= {WIDTH{1'b0}};
            r_res_vld <= {NREQ{1'b0}};
            r_tmo_err <= 1'b0;
        end else begin
            // Pulses default low; the branches below raise them for one cycle
            r_gnt     <= {NREQ{1'b0}};
            r_fa_en   <= 1'b0;
            r_res_vld <= {NREQ{1'b0}};
            r_tmo_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // fa_vld is deliberately ignored here (stray/stale valid)
                    if (w_found) begin
                        r_gnt    <= {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                        r_fa_op1 <= w_op1[w_win];
                        r_fa_op2 <= w_op2[w_win];
                        r_fa_cin <= cin_in[w_win];
                        r_fa_mod <= mod_in;
                        r_fa_en  <= 1'b1;
                        r_owner  <= w_win;
                        r_ptr    <= w_ptr_nxt;
                        r_cnt    <= {CW{1'b0}};
                        r_state  <= ST_WAIT;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // A valid arriving on the timeout cycle still wins
                    if (fa_vld) begin
                        r_res     <= fa_sum;
                        r_res_vld <= w_owner_oh;
                        r_state   <= ST_IDLE;
                    end else if (r_cnt == CW'(TMO)) begin
                        r_res     <= {WIDTH{1'b0}};
                        r_res_vld <= w_owner_oh;
                        r_tmo_err <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt     <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign fa_op1  = r_fa_op1;
    assign fa_op2  = r_fa_op2;
    assign fa_mod  = r_fa_mod;
    assign fa_cin  = r_fa_cin;
    assign fa_en   = r_fa_en;
    assign res     = r_res;
    assign res_vld = r_res_vld;
    assign tmo_err = r_tmo_err;
    assign busy    = (r_state == ST_WAIT);

endmodule

// File: doc/modfa_arb.md
Name: modfa_arb

Overview:
Round-robin arbiter and sequencer that shares one modular adder (op1+op2+cin mod mod, fixed-latency, en/vld interface) among NREQ requesters. It captures the winning requester's operands, issues a one-cycle enable to the adder and waits for its valid. It then routes the sum back to the owning requester. A watchdog bounds the wait so that a requester can never hang.

Parameters:
WIDTH, 256, operand/modulus/sum width
NREQ, 4, number of requesters (>=2)
TMO, 64, max WAIT cycles before timeout; must exceed adder latency (20)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; synchronous, active-high
req  in  NREQ  request per requester; held until gnt seen
op1_in  in  NREQ*WIDTH  operand 1, slice i = requester i
op2_in  in  NREQ*WIDTH  operand 2, slice i
cin_in  in  NREQ  carry-in per requester
mod_in  in  WIDTH  shared modulus (configuration)
gnt  out  NREQ  one-hot, 1-cycle pulse: operands captured
fa_op1  out  WIDTH  to adder op1 (registered)
fa_op2  out  WIDTH  to adder op2 (registered)
fa_mod  out  WIDTH  to adder mod (registered at grant)
fa_cin  out  1  to adder cin
fa_en  out  1  to adder en, 1-cycle pulse
fa_sum  in  WIDTH  adder sum
fa_vld  in  1  adder valid
res  out  WIDTH  result to owner
res_vld  out  NREQ  one-hot, 1-cycle pulse to owner
tmo_err  out  1  1-cycle pulse with res_vld on timeout
busy  out  1  state != IDLE

Behaviour:
- Reset, synchronous: state=IDLE, ptr=0, owner=0, cnt=0. All outputs are 0: gnt, fa_*, res, res_vld, tmo_err and busy.
- States: IDLE and WAIT.
- IDLE, req==0: hold; gnt, fa_en, res_vld and tmo_err are 0.
- IDLE, req!=0: winner i = first set bit scanning ptr, ptr+1, ... (mod NREQ). At the clock edge:
  - gnt<=onehot(i); fa_op1/fa_op2/fa_cin <= slice i; fa_mod<=mod_in; fa_en<=1.
  - owner<=i; ptr<=(i+1)%NREQ; cnt<=0; state<=WAIT.
- Grant timing: with req sampled in cycle t, gnt and fa_en are high in cycle t+1 only. Call that cycle k=0 of WAIT.
- req is not sampled in WAIT. A requester must drop req when it sees gnt. A req still held after result delivery counts as a new request.
- WAIT, each cycle:
  - fa_vld=1: res<=fa_sum; res_vld<=onehot(owner); state<=IDLE.
  - Else cnt==TMO: res<=0; res_vld<=onehot(owner); tmo_err<=1; state<=IDLE.
  - Else cnt<=cnt+1.
  - If fa_vld and cnt==TMO occur in the same cycle, fa_vld wins and tmo_err stays 0.
- Latency: with adder latency L, fa_vld arrives at k=L and res_vld at k=L+1, i.e. gnt+L+1. The next gnt comes at the earliest one cycle after res_vld, giving a per-op period of L+2.
- Timeout: res_vld and tmo_err at gnt+TMO+1.
- cnt width: clog2(TMO+1). It saturates via the state change and does not wrap.
- fa_vld while in IDLE (stray or left over from before reset) is ignored: no res_vld and no state change.
- fa_op*, fa_cin and fa_mod hold their values until the next grant. mod_in changes during WAIT do not affect the op in flight.
- gnt, res_vld and tmo_err are registered single-cycle pulses. busy is decoded from the state register.
- Reset mid-WAIT: abort; the pending result is never delivered; ptr returns to 0.

Test Plan:
1. Reset, then req=4'b0001, op1=5, op2=7, cin=1, mod=11, adder model L=20 -> gnt=0001 and fa_en for 1 cycle at t+1; res=2, res_vld=0001 at gnt+21; tmo_err=0; busy low after.
2. req=4'b1111 held after reset, each requester drops req on its gnt -> grant order 0,1,2,3; gnt spacing 22 cycles; each res_vld goes to the matching requester with the correct sum.
3. req0 and req2 re-asserted immediately after each result -> grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
4. Adder model never asserts fa_vld, TMO=64 -> res_vld to owner and tmo_err=1 at gnt+65, res=0; next pending req is granted one cycle later.
5. rst at WAIT k=10, model then emits fa_vld at k=20 -> all outputs 0 the cycle after rst; stray fa_vld yields no res_vld; next req0|req3 grants 0 (ptr=0).
6. mod_in changed from 11 to 13 at k=5 with op1=10, op2=4 -> fa_mod stays 11, res=3; fa_vld coincident with cnt==TMO (model L=TMO) -> res=sum, tmo_err=0.
